// File: rtl/div_clk_meter.sv
// Period / high-time meter for a divided clock or enable tick.
// Optional stall detection is enabled with DIV_CLK_METER_TIMEOUT_EN.
module div_clk_meter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             div_in,
    output logic             edge_tick,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             stalled
);

`ifdef DIV_CLK_METER_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, ARM, MEASURE, STALL} state_t;
`else
    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    state_t           state_d;
    logic             s1;
    logic             s2;
    logic             prev;
    logic             rise;
    logic             run;
    logic             report;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] hcnt_inc;

    assign rise     = s2 & ~prev;
    assign run      = enable && (state_q != IDLE);
    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign hcnt_inc = (hcnt == CNT_MAX) ? hcnt : hcnt + 1'b1;

`ifdef DIV_CLK_METER_TIMEOUT_EN
    logic timeout_hit;
    // cnt+1 == TIMEOUT, written without the widening add
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    assign stalled     = (state_q == STALL);
`else
    assign stalled = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= div_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        report  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: state_d = ARM;
                ARM: begin
                    if (rise) begin
                        state_d = MEASURE;
`ifdef DIV_CLK_METER_TIMEOUT_EN
                    end else if (timeout_hit) begin
                        state_d = STALL;
`endif
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        report = 1'b1;
`ifdef DIV_CLK_METER_TIMEOUT_EN
                    end else if (timeout_hit) begin
                        state_d = STALL;
`endif
                    end
                end
`ifdef DIV_CLK_METER_TIMEOUT_EN
                STALL: begin
                    if (rise) begin
                        state_d = MEASURE;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // hcnt restarts at 1 because the rise cycle itself is high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            hcnt <= '0;
        end else if (!run) begin
            cnt  <= '0;
            hcnt <= '0;
        end else if (rise) begin
            cnt  <= '0;
            hcnt <= CNT_W'(1);
        end else begin
            cnt <= cnt_inc;
            if (s2) begin
                hcnt <= hcnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_tick  <= 1'b0;
            meas_valid <= 1'b0;
            period     <= '0;
            high_time  <= '0;
        end else begin
            edge_tick  <= rise;
            meas_valid <= report;
            if (report) begin
                period    <= cnt_inc;
                high_time <= hcnt;
            end
        end
    end

endmodule

// File: tb/tb_div_clk_meter.sv
// Directed self-checking bench for div_clk_meter.
// Stall checks compile only when DIV_CLK_METER_TIMEOUT_EN is defined.
module tb_div_clk_meter;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        div_in;
    logic        edge_tick;
    logic        meas_valid;
    logic [15:0] period;
    logic [15:0] high_time;
    logic        stalled;

    int checks;
    int failures;
    int cyc;
    int ticks;
    int mvs;
    int bad;
    int first_p;
    int stall_cyc;
    int last_tick_cyc;
    int exp_p;
    int exp_h;

    div_clk_meter #(.CNT_W(16), .TIMEOUT(1000)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .div_in     (div_in),
        .edge_tick  (edge_tick),
        .meas_valid (meas_valid),
        .period     (period),
        .high_time  (high_time),
        .stalled    (stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (edge_tick === 1'b1) begin
            ticks         = ticks + 1;
            last_tick_cyc = cyc;
        end
        if (meas_valid === 1'b1) begin
            mvs = mvs + 1;
            if (mvs == 1) first_p = int'(period);
            if (int'(period) != exp_p || int'(high_time) != exp_h) bad = bad + 1;
        end
        if (stalled === 1'b1 && stall_cyc == 0) stall_cyc = cyc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        @(posedge clk);
        #1;
        ticks     = 0;
        mvs       = 0;
        bad       = 0;
        first_p   = -1;
        stall_cyc = 0;
        @(negedge clk);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic drive(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            div_in = 1'b1;
            repeat (hi) @(negedge clk);
            div_in = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        ticks = 0; mvs = 0; bad = 0; first_p = -1;
        stall_cyc = 0; last_tick_cyc = 0;
        exp_p = 0; exp_h = 0;
        reset = 1'b0; enable = 1'b0; div_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_edge_tick", edge_tick, 0);
        chk("rst_meas_valid", meas_valid, 0);
        chk("rst_period", period, 0);
        chk("rst_high_time", high_time, 0);
        chk("rst_stalled", stalled, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // edge latency, enable low: edge_tick still pulses
        div_in = 1'b1;
        @(negedge clk); chk("lat_e1", edge_tick, 0);
        @(negedge clk); chk("lat_e2", edge_tick, 0);
        @(negedge clk); chk("lat_e3", edge_tick, 1);
        @(negedge clk); chk("lat_e4", edge_tick, 0);
        div_in = 1'b0;
        repeat (3) @(negedge clk);

        // mod-2 divider
        enable = 1'b1;
        exp_p = 2; exp_h = 1;
        clr();
        drive(1, 1, 10);
        settle();
        chk("m2_ticks", ticks, 10);
        chk("m2_valids", mvs, 9);
        chk("m2_bad", bad, 0);
        chk("m2_period", period, 2);
        chk("m2_high", high_time, 1);

        // period 10 high 3 after re-arming
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        exp_p = 10; exp_h = 3;
        clr();
        drive(3, 7, 6);
        settle();
        chk("p10_ticks", ticks, 6);
        chk("p10_valids", mvs, 5);
        chk("p10_bad", bad, 0);
        chk("p10_period", period, 10);
        chk("p10_high", high_time, 3);

        // enable dropped mid-period
        enable = 1'b0;
        clr();
        drive(3, 7, 2);
        settle();
        chk("dis_ticks", ticks, 2);
        chk("dis_valids", mvs, 0);
        chk("dis_period_hold", period, 10);
        chk("dis_high_hold", high_time, 3);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        exp_p = 6; exp_h = 2;
        clr();
        drive(2, 4, 3);
        settle();
        chk("reen_valids", mvs, 2);
        chk("reen_bad", bad, 0);
        chk("reen_period", period, 6);

        // asynchronous reset mid-period
        @(negedge clk);
        div_in = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("ar_edge_tick", edge_tick, 0);
        chk("ar_meas_valid", meas_valid, 0);
        chk("ar_period", period, 0);
        chk("ar_high_time", high_time, 0);
        chk("ar_stalled", stalled, 0);
        @(negedge clk);
        div_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        clr();
        drive(2, 4, 2);
        settle();
        chk("ar_ticks", ticks, 2);
        chk("ar_valids", mvs, 1);
        chk("ar_bad", bad, 0);

`ifdef DIV_CLK_METER_TIMEOUT_EN
        // stall after 1000 idle cycles
        clr();
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            #1;
            if (stall_cyc != 0) break;
        end
        chk("st_seen", (stall_cyc != 0), 1);
        chk("st_delay", stall_cyc - last_tick_cyc, 1000);
        chk("st_level", stalled, 1);
        clr();
        drive(2, 4, 2);
        settle();
        chk("st_cleared", stalled, 0);
        chk("st_ticks", ticks, 2);
        chk("st_valids", mvs, 1);
        chk("st_period", period, 6);
        chk("st_high", high_time, 2);
`else
        // long gap saturates the period counter
        exp_p = 4; exp_h = 2;
        clr();
        repeat (70000) @(negedge clk);
        drive(2, 2, 3);
        settle();
        chk("sat_stalled", stall_cyc, 0);
        chk("sat_valids", mvs, 3);
        chk("sat_first", first_p, 65535);
        chk("sat_bad", bad, 1);
        chk("sat_period", period, 4);
        chk("sat_high", high_time, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_clk_meter.md
# div_clk_meter

Measures the divided clock/enable tick produced by the team's clock-divider stage: it synchronizes the square wave, detects its rising edges and reports period and high time in `clk` cycles. It flags a stalled divider output. It sits beside the divider on the system clock and feeds status and debug logic. It checks that the divided tick really runs at the intended ratio (2 cycles for the mod-2 divider).

## Interface
- `CNT_W`, 16: width of period/high-time counters and outputs.
- `TIMEOUT`, 1000: cycles without a rising edge before `stalled` asserts; legal range 2 .. 2^CNT_W-1.

- `clk` in 1: system clock, single clock domain.
- `reset` in 1: reset, asynchronous, active-low.
- `enable` in 1: measurement enable; low forces IDLE.
- `div_in` in 1: divided clock/tick under test; may be asynchronous to `clk`.
- `edge_tick` out 1: one-cycle pulse per detected rising edge of `div_in`.
- `meas_valid` out 1: one-cycle pulse when `period`/`high_time` update.
- `period` out CNT_W: last complete period in `clk` cycles.
- `high_time` out CNT_W: synchronized-high cycles within that period.
- `stalled` out 1: level, no rising edge for `TIMEOUT` cycles.

## Operation
- Front end: 2-flop synchronizer (`s1`, `s2`) plus history flop `prev`. `rise = s2 & ~prev`. The synchronizer and edge detector run whenever out of reset, independent of `enable`.
- `edge_tick` is registered from `rise` and pulses regardless of FSM state.
- Counters:
  - `cnt` clears to 0 on `rise`, otherwise increments and saturates at 2^CNT_W-1.
  - `hcnt` clears on `rise` to 1, otherwise increments while `s2`=1, and saturates.
- FSM states:
  - IDLE: entered on reset or when `enable`=0. Counters held at 0, no `meas_valid`, `stalled`=0. Go to ARM when `enable`=1.
  - ARM: wait for first `rise`, then go to MEASURE. This partial period is never reported.
  - MEASURE: on `rise`, `period <= sat(cnt+1)`, `high_time <= hcnt_final`, and `meas_valid` pulses; stay in MEASURE. If `cnt+1` reaches `TIMEOUT` with no `rise`, go to STALL.
  - STALL: `stalled`=1. On `rise`, clear `stalled`, restart counters and go to MEASURE without a `meas_valid`.
- ARM also times out to STALL after `TIMEOUT` cycles.
- `enable` falling in any state: go to IDLE next cycle. `period` and `high_time` hold their last values; a pending measurement is discarded.
- Simultaneous `rise` and timeout in the same cycle: `rise` wins, with no STALL.
- Arithmetic is unsigned; saturating adds never wrap.

## Timing
- Reset values: `edge_tick`=0, `meas_valid`=0, `period`=0, `high_time`=0, `stalled`=0, FSM=IDLE, all synchronizer flops 0.
- Edge latency: `div_in` rises before clk edge E1. `s2`=1 after E2. `edge_tick`=1 for the cycle after E3.
- `meas_valid`, `period` and `high_time` update on the same edge as the `edge_tick` that ends the period.
- `stalled` asserts exactly `TIMEOUT` cycles after the edge that asserted the last `edge_tick` (or after ARM entry). It deasserts on the edge that asserts the next `edge_tick`.
- Reset assertion mid-operation clears every output immediately (asynchronous). After release, the first `meas_valid` requires two rising edges.
- Minimum measurable period is 2 cycles; `div_in` faster than `clk`/2 aliases and is not required to measure correctly.

## Configuration
- `DIV_CLK_METER_TIMEOUT_EN`
  - Defined: STALL state, timeout compare and `stalled` output are implemented as described.
  - Undefined: no STALL state; `stalled` is tied to 0. MEASURE waits indefinitely, and `period` reports the saturated count 2^CNT_W-1 when the gap exceeds the counter range.

## Test plan
- Mod-2 divider pattern (toggle every `clk`), `enable`=1: `edge_tick` every 2 cycles. The first `meas_valid` comes at the second `edge_tick`, then repeats with `period`=2, `high_time`=1.
- `div_in` period 10, high 3: the first edge gives `edge_tick` only, then `period`=10, `high_time`=3 on every following edge.
- Macro defined, `TIMEOUT`=1000, `div_in` held 0 after edges: `stalled`=1 exactly 1000 cycles after the last `edge_tick`. The next rise clears it with no `meas_valid`, and the following rise reports a valid period.
- `reset` low mid-period with `period`=10 reported: all outputs read 0 immediately. After release, two rises are needed before `meas_valid`.
- `enable` dropped mid-period: no `meas_valid`, `period`/`high_time` hold 10/3. On re-enable, the first rise arms and the second reports.
- Macro undefined, `CNT_W`=16, `div_in` low for 70000 cycles then toggling with period 4: `stalled` stays 0. The first report is `period`=65535, then `period`=4.
